// File: rtl/jtcop_pkg.sv
// Shared definitions for the object-ROM slot: FSM encoding and region base.
package jtcop_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BEAT0 = 2'd2,
        ST_BEAT1 = 2'd3
    } objrom_state_t;

    // Default SDRAM half-word base of the object graphics region
    localparam logic [21:0] JTCOP_OBJ_OFFSET = 22'h0;

endpackage

// File: rtl/jtcop_objrom_slot.sv
// Object-engine ROM responder: a single-entry line in front of a 16-bit
// SDRAM bank. A miss becomes one two-beat burst; the low half arrives first.
module jtcop_objrom_slot
    import jtcop_pkg::*;
#(
    parameter int              AW     = 17,
    parameter int              SDW    = 22,
    parameter logic [SDW-1:0]  OFFSET = SDW'(JTCOP_OBJ_OFFSET)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rom_cs,
    input  logic [AW-1:0]  rom_addr,
    output logic [31:0]    rom_data,
    output logic           rom_ok,
    output logic           sdram_rd,
    output logic [SDW-1:0] sdram_addr,
    input  logic           sdram_ack,
    input  logic           sdram_dok,
    input  logic [15:0]    sdram_din,
    input  logic           flush
);

    objrom_state_t  state_reg, state_next;
    logic [AW-1:0]  req_addr_reg, req_addr_next;
    logic [AW-1:0]  tag_reg, tag_next;
    logic           valid_reg, valid_next;
    // Set when a flush lands while a burst is outstanding; the burst must
    // still run to completion, but its result must not become valid.
    logic           discard_reg, discard_next;
    logic [15:0]    lo_reg, lo_next;
    logic [31:0]    rom_data_next;
    logic           sdram_rd_next;
    logic [SDW-1:0] sdram_addr_next;
    logic           hit;
    logic [SDW-1:0] beat0_addr;

    // Word address -> half-word address; overflow past SDW bits wraps
    assign beat0_addr = OFFSET + SDW'({rom_addr, 1'b0});

    // Hit is combinational so rom_ok tracks rom_addr within the same cycle
    assign hit    = valid_reg & (tag_reg == rom_addr);
    assign rom_ok = rom_cs & hit;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            req_addr_reg <= '0;
            tag_reg      <= '0;
            valid_reg    <= 1'b0;
            discard_reg  <= 1'b0;
            lo_reg       <= '0;
            rom_data     <= '0;
            sdram_rd     <= 1'b0;
            sdram_addr   <= '0;
        end else begin
            state_reg    <= state_next;
            req_addr_reg <= req_addr_next;
            tag_reg      <= tag_next;
            valid_reg    <= valid_next;
            discard_reg  <= discard_next;
            lo_reg       <= lo_next;
            rom_data     <= rom_data_next;
            sdram_rd     <= sdram_rd_next;
            sdram_addr   <= sdram_addr_next;
        end
    end

    // Next-state and fill logic
    always_comb begin
        state_next      = state_reg;
        req_addr_next   = req_addr_reg;
        tag_next        = tag_reg;
        valid_next      = valid_reg & ~flush;
        discard_next    = discard_reg | flush;
        lo_next         = lo_reg;
        rom_data_next   = rom_data;
        sdram_rd_next   = sdram_rd;
        sdram_addr_next = sdram_addr;

        case (state_reg)
            ST_IDLE: begin
                // A flush seen here only affects the current line
                discard_next = 1'b0;
                if (rom_cs && !hit) begin
                    req_addr_next   = rom_addr;
                    sdram_addr_next = beat0_addr;
                    sdram_rd_next   = 1'b1;
                    state_next      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    sdram_rd_next = 1'b0;
                    // The first beat may arrive together with the ack
                    if (sdram_dok) begin
                        lo_next    = sdram_din;
                        state_next = ST_BEAT1;
                    end else begin
                        state_next = ST_BEAT0;
                    end
                end
            end
            ST_BEAT0: begin
                if (sdram_dok) begin
                    lo_next    = sdram_din;
                    state_next = ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                if (sdram_dok) begin
                    state_next = ST_IDLE;
                    if (!(discard_reg || flush)) begin
                        rom_data_next = {sdram_din, lo_reg};
                        tag_next      = req_addr_reg;
                        valid_next    = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
